dm_cache_read_ctrl: RTL and testbench
=====================================

Name: dm_cache_read_ctrl

Overview:
- Direct-mapped, read-only cache controller between the CPU load port and main memory.
- On a miss it issues a block read to main memory and receives a 128-bit block of 4 aligned 32-bit words.
- It fills the line and then returns the requested word.
- Acts as the requester end of the main-memory block-read interface; keeps hit/access statistics for the cache study.

Parameters:
- ADDR_W, 15, word address width (CPU and memory).
- WORD_W, 32, data word width.
- INDEX_W, 10, line index bits (1024 lines); tag width = ADDR_W-2-INDEX_W = 3.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  read request, sampled only in IDLE.
- cpu_addr  in  ADDR_W  word address; fields: tag [14:12], index [11:2], word offset [1:0].
- cpu_ready  out  1  one-cycle pulse; cpu_rdata is valid this cycle.
- cpu_rdata  out  WORD_W  returned word.
- cpu_hit  out  1  qualifies cpu_ready: 1 = hit, 0 = serviced by fill.
- mem_req  out  1  block read request; held until mem_ready.
- mem_addr  out  ADDR_W  block-aligned address {tag,index,2'b00}.
- mem_ready  in  1  memory block valid this cycle.
- mem_rdata  in  4*WORD_W  block; word k occupies bits [32k+31:32k].
- hit_count  out  CNT_W  saturating hit counter.
- access_count  out  CNT_W  saturating accepted-request counter.

Behaviour:
- Reset (async): state IDLE; all valid bits 0.
  - Outputs cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_addr, hit_count, access_count all 0.
  - Tag and data arrays are not reset.
- States: IDLE, COMPARE, FETCH, RESPOND.
- IDLE:
  - cpu_req=1 latches cpu_addr, increments access_count (saturates at all-ones), and moves to COMPARE.
- COMPARE (one cycle after acceptance):
  - Hit = valid[index] && tag_array[index]==tag.
  - On hit: cpu_ready=1, cpu_hit=1, cpu_rdata=data[index] word[offset]; hit_count++ (saturating); return to IDLE.
  - On miss: register mem_addr={tag,index,2'b00}, assert mem_req, go to FETCH.
- FETCH:
  - mem_req and mem_addr stay stable until mem_ready=1. No timeout.
  - On mem_ready: write mem_rdata to data[index], write tag, set valid[index], capture word[offset]; deassert mem_req next edge; go to RESPOND.
- RESPOND: cpu_ready=1, cpu_hit=0, cpu_rdata=captured word; go to IDLE.
- Latency:
  - Hit: cpu_ready 1 cycle after acceptance.
  - Miss: cpu_ready 1 cycle after the mem_ready cycle; minimum 3 cycles after acceptance.
- cpu_ready and cpu_hit are single-cycle pulses. cpu_rdata holds its last value otherwise.
- Back-to-back: the next request is accepted in the IDLE cycle after cpu_ready, giving at most 1 request per 2 cycles.
- cpu_req outside IDLE is ignored (not queued). cpu_addr changes after acceptance have no effect.
- mem_ready outside FETCH is ignored; no array write occurs.
- Conflict miss (same index, different tag) overwrites the line. There is no write-back, since the cache is read-only.
- Reset during FETCH:
  - mem_req drops asynchronously and the line is not written.
  - A mem_ready arriving later is ignored.
- Counters stop at 16'hFFFF and do not wrap.
- Addresses >= 32000 are forwarded unchanged; range checking belongs to memory.

Decomposition:
- Package cache_pkg: ADDR_W, WORD_W, INDEX_W, TAG_W, OFFSET_W=2, WORDS_PER_BLOCK=4, state enum {IDLE,COMPARE,FETCH,RESPOND}, field-extract functions (tag/index/offset, word select).
- Sub-module cache_line_array:
  - Valid, tag and data storage; asynchronous read, synchronous write, async-reset valid bits.
  - The controller FSM and counters stay in dm_cache_read_ctrl.

Test Plan:
- Cold miss: after reset, read 0x0005; memory answers 2 cycles after mem_req with {DDDDDDDD,CCCCCCCC,BBBBBBBB,AAAAAAAA}.
  - Required: mem_addr=0x0004; cpu_ready with cpu_hit=0 and rdata=BBBBBBBB; access_count=1, hit_count=0.
- Hit in same block: then read 0x0006.
  - Required: no mem_req; cpu_ready 1 cycle after acceptance, cpu_hit=1, rdata=CCCCCCCC; hit_count=1.
- Conflict: read 0x1005 (tag 1, index 1) with block word1=11111111, then read 0x0005 again.
  - Required: mem_addr=0x1004 returning 11111111.
  - The second read misses again with mem_addr=0x0004.
- Stalled memory: hold mem_ready low 6 cycles.
  - Required: mem_req=1 and mem_addr constant throughout; cpu_req pulses during FETCH are ignored and access_count is unchanged.
- Reset mid-fetch: assert rst in FETCH for read 0x0008, then pulse mem_ready.
  - Required: mem_req=0 immediately; all outputs 0.
  - The following read 0x0008 misses with mem_addr=0x0008.
- Saturation: preload-equivalent 65540 hits to one line.
  - Required: hit_count and access_count stop at 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: geometry, FSM state type and address/block field helpers for the direct-mapped read cache.
package cache_pkg;
  localparam int ADDR_W = 15;
  localparam int WORD_W = 32;
  localparam int INDEX_W = 10;
  localparam int OFFSET_W = 2;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, COMPARE, FETCH, RESPOND} state_e;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (ADDR_W - TAG_W));
  endfunction
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return INDEX_W'(a >> OFFSET_W);
  endfunction
  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return OFFSET_W'(a);
  endfunction
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] b, input logic [OFFSET_W-1:0] o);
    return b[WORD_W*int'(o) +: WORD_W];
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage; combinational read, clocked write, valid bits cleared by reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_data_i
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else if (we_i) valid_q[wr_index_i] <= 1'b1;
  always_ff @(posedge clk)
    if (we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o = tag_q[rd_index_i];
  assign rd_data_o = data_q[rd_index_i];
endmodule

// File: rtl/dm_cache_read_ctrl.sv
// dm_cache_read_ctrl: direct-mapped read-only cache controller with block refill and hit/access statistics.
module dm_cache_read_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               cpu_hit,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   access_count
);
  state_e state_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [WORD_W-1:0] rdata_q;
  logic ready_q, hit_q, mem_req_q;
  logic [CNT_W-1:0] hit_cnt_q, acc_cnt_q;
  logic lk_valid, lookup_hit, fill;
  logic [TAG_W-1:0] lk_tag;
  logic [BLOCK_W-1:0] lk_data;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  // Lookup runs on the incoming address in IDLE so a hit can answer in the very next cycle.
  assign lookup_hit = lk_valid && lk_tag == addr_tag(cpu_addr);
  assign fill = state_q == FETCH && mem_ready;
  cache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (addr_index(cpu_addr)),
    .rd_valid_o (lk_valid),
    .rd_tag_o   (lk_tag),
    .rd_data_o  (lk_data),
    .we_i       (fill),
    .wr_index_i (addr_index(addr_q)),
    .wr_tag_i   (addr_tag(addr_q)),
    .wr_data_i  (mem_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      mem_addr_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hit_q <= 1'b0;
      mem_req_q <= 1'b0;
      hit_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      ready_q <= 1'b0;
      hit_q <= 1'b0;
      case (state_q)
        IDLE: if (cpu_req) begin
          addr_q <= cpu_addr;
          acc_cnt_q <= sat_inc(acc_cnt_q);
          ready_q <= lookup_hit;
          hit_q <= lookup_hit;
          if (lookup_hit) begin
            rdata_q <= word_sel(lk_data, addr_offset(cpu_addr));
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end
          state_q <= COMPARE;
        end
        COMPARE: begin
          if (!hit_q) begin
            mem_addr_q <= {addr_q[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
            mem_req_q <= 1'b1;
          end
          state_q <= hit_q ? IDLE : FETCH;
        end
        FETCH: if (mem_ready) begin
          mem_req_q <= 1'b0;
          ready_q <= 1'b1;
          rdata_q <= word_sel(mem_rdata, addr_offset(addr_q));
          state_q <= RESPOND;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign cpu_ready = ready_q;
  assign cpu_hit = hit_q;
  assign cpu_rdata = rdata_q;
  assign mem_req = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_count = hit_cnt_q;
  assign access_count = acc_cnt_q;
endmodule

// File: tb/tb_dm_cache_read_ctrl.sv
// tb_dm_cache_read_ctrl: directed + random reads against a line-ownership model; a narrow-counter twin checks saturation.
module tb_dm_cache_read_ctrl;
  logic clk = 1'b0;
  logic rst, cpu_req, mem_ready;
  logic [14:0] cpu_addr;
  logic [127:0] mem_rdata;
  logic ready_a, hit_a, mreq_a, ready_b, hit_b, mreq_b;
  logic [31:0] rdata_a, rdata_b;
  logic [14:0] maddr_a, maddr_b;
  logic [15:0] hc_a, ac_a;
  logic [4:0] hc_b, ac_b;
  int vecs = 0, errs = 0;
  int acc_m = 0, hit_m = 0;
  logic [127:0] mem_img [logic [14:0]];
  logic [14:0] owner [int];
  always #5 clk = ~clk;

  dm_cache_read_ctrl u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(ready_a), .cpu_rdata(rdata_a), .cpu_hit(hit_a),
    .mem_req(mreq_a), .mem_addr(maddr_a), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hc_a), .access_count(ac_a)
  );
  dm_cache_read_ctrl #(.CNT_W(5)) u_sat (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(ready_b), .cpu_rdata(rdata_b), .cpu_hit(hit_b),
    .mem_req(mreq_b), .mem_addr(maddr_b), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hc_b), .access_count(ac_b)
  );

  function automatic int sat(input int x, input int m);
    return x > m ? m : x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts();
    chk("hit_count", 128'(hc_a), 128'(sat(hit_m, 65535)));
    chk("access_count", 128'(ac_a), 128'(sat(acc_m, 65535)));
    chk("hit_count_sat", 128'(hc_b), 128'(sat(hit_m, 31)));
    chk("access_count_sat", 128'(ac_b), 128'(sat(acc_m, 31)));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 128'(ready_a), 0);
    chk({tag, "_hit"}, 128'(hit_a), 0);
    chk({tag, "_mem_req"}, 128'(mreq_a), 0);
    chk({tag, "_mem_req_sat"}, 128'(mreq_b), 0);
  endtask

  task automatic do_read(input logic [14:0] a, input int delay, input bit poke);
    logic [14:0] blk;
    logic [127:0] d;
    logic [31:0] w;
    int idx;
    bit hit;
    blk = {a[14:2], 2'b00};
    idx = int'(a[11:2]);
    if (!mem_img.exists(blk)) mem_img[blk] = {$urandom, $urandom, $urandom, $urandom};
    d = mem_img[blk];
    w = d[32*int'(a[1:0]) +: 32];
    hit = owner.exists(idx) && owner[idx] == blk;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
    if (poke) cpu_addr = 15'($urandom);
    acc_m++;
    chk("ready_after_accept", 128'(ready_a), 128'(hit));
    chk("hit_after_accept", 128'(hit_a), 128'(hit));
    chk("no_mem_req_compare", 128'(mreq_a), 0);
    if (hit) begin
      hit_m++;
      chk("hit_rdata", 128'(rdata_a), 128'(w));
      chk("hit_rdata_sat", 128'(rdata_b), 128'(w));
      chk_counts();
    end else begin
      @(negedge clk);
      chk("fetch_mem_req", 128'(mreq_a), 1);
      chk("fetch_mem_addr", 128'(maddr_a), 128'(blk));
      chk("fetch_mem_addr_sat", 128'(maddr_b), 128'(blk));
      for (int i = 0; i < delay; i++) begin
        if (poke) begin
          cpu_req = 1'b1;
          cpu_addr = 15'($urandom);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        chk("stall_mem_req", 128'(mreq_a), 1);
        chk("stall_mem_addr", 128'(maddr_a), 128'(blk));
        chk("stall_ready", 128'(ready_a), 0);
        chk("stall_access_count", 128'(ac_a), 128'(sat(acc_m, 65535)));
      end
      mem_ready = 1'b1;
      mem_rdata = d;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      owner[idx] = blk;
      chk("fill_ready", 128'(ready_a), 1);
      chk("fill_hit", 128'(hit_a), 0);
      chk("fill_rdata", 128'(rdata_a), 128'(w));
      chk("fill_rdata_sat", 128'(rdata_b), 128'(w));
      chk("fill_mem_req_drop", 128'(mreq_a), 0);
      chk_counts();
    end
    @(negedge clk);
    chk("ready_pulse_end", 128'(ready_a), 0);
    chk("rdata_held", 128'(rdata_a), 128'(w));
  endtask

  initial begin
    int ix_pool [4] = '{3, 4, 200, 1023};
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_img[15'h0004] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    mem_img[15'h1004] = {32'h44444444, 32'h33333333, 32'h11111111, 32'h22222222};
    #12;
    chk_idle_outputs("reset");
    chk("reset_rdata", 128'(rdata_a), 0);
    chk("reset_mem_addr", 128'(maddr_a), 0);
    chk_counts();
    @(negedge clk);
    rst = 1'b0;
    // Cold miss, same-block hit, conflict pair.
    do_read(15'h0005, 2, 1'b0);
    do_read(15'h0006, 0, 1'b0);
    do_read(15'h1005, 1, 1'b0);
    do_read(15'h0005, 0, 1'b0);
    // Stalled memory with ignored requests during FETCH.
    do_read(15'h0105, 6, 1'b1);
    // Reset in the middle of a fetch.
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 15'h0008;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_reset_mem_req", 128'(mreq_a), 1);
    #1 rst = 1'b1;
    #1;
    acc_m = 0;
    hit_m = 0;
    owner.delete();
    chk_idle_outputs("midfetch_reset");
    chk("midfetch_reset_rdata", 128'(rdata_a), 0);
    chk("midfetch_reset_mem_addr", 128'(maddr_a), 0);
    chk_counts();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    mem_ready = 1'b0;
    chk_idle_outputs("late_mem_ready");
    do_read(15'h0008, 0, 1'b0);
    do_read(15'h0005, 1, 1'b0);
    // Repeated hits drive the narrow counters into saturation.
    for (int i = 0; i < 40; i++) do_read(15'h0006, 0, 1'b0);
    for (int i = 0; i < 150; i++)
      do_read(15'($urandom_range(0, 2) * 4096 + ix_pool[$urandom_range(0, 3)] * 4 + $urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    chk_counts();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
